// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-cache request/response, decode-side instruction
// buffer head with handshake, and the execute-stage redirect.
//   master : the fetch unit (drives cache request and buffer head)
//   slave  : the environment (cache, decode and execute stages)
// Signals
//   ic_addr/ic_rd_req         fetch -> cache   registered address, 1-cycle request pulse
//   ic_ready/ic_rd_data       cache -> fetch   response strobe and instruction word
//   inst_valid/data/pc        fetch -> decode  buffer head
//   inst_ready                decode -> fetch  head accepted
//   redirect_valid/pc         execute -> fetch new fetch PC strobe
//   fifo_count                fetch -> any     buffer occupancy
interface inst_fetch_unit_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     ic_addr;
  logic            ic_rd_req;
  logic            ic_ready;
  logic [31:0]     ic_rd_data;
  logic            inst_valid;
  logic [31:0]     inst_data;
  logic [31:0]     inst_pc;
  logic            inst_ready;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic [CntW-1:0] fifo_count;

  modport master (
    output ic_addr, ic_rd_req, inst_valid, inst_data, inst_pc, fifo_count,
    input  ic_ready, ic_rd_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  ic_addr, ic_rd_req, inst_valid, inst_data, inst_pc, fifo_count,
    output ic_ready, ic_rd_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage sitting in front of the instruction cache. Keeps the fetch PC,
// issues one outstanding single-word read at a time and buffers {pc, instruction} pairs
// in a small FIFO for decode. Redirects flush the buffer and retarget the PC; a redirect
// that lands while a read is in flight marks that read to be discarded on return.
// Ports
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   inst_fetch_unit_if.master (cache, decode and redirect signals)
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rstn,
  inst_fetch_unit_if.master bus
);

  localparam int unsigned    PtrW        = $clog2(FIFO_DEPTH);
  localparam int unsigned    CntW        = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt   = CntW'(FIFO_DEPTH);
  localparam logic [31:0]    ResetPcWord = {RESET_PC[31:2], 2'b00};

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic            drop_q, drop_d;

  logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            push, pop, empty, full;
  logic [31:0]     redirect_word;

  assign empty         = (count_q == '0);
  assign full          = (count_q == DepthCnt);
  assign redirect_word = {bus.redirect_pc[31:2], 2'b00};
  // A redirect squashes any pop seen in the same cycle.
  assign pop           = !empty && bus.inst_ready && !bus.redirect_valid;

  // Fetch FSM and PC update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = 1'b0;
    drop_d  = drop_q;
    push    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Occupancy only falls while a read is in flight, so checking here is enough.
        if (!bus.redirect_valid && !full) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.ic_ready) begin
          state_d = StIdle;
          drop_d  = 1'b0;
          if (!drop_q && !bus.redirect_valid) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end else if (bus.redirect_valid) begin
          // addr_q must stay put until the cache answers; just discard the answer.
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.redirect_valid) begin
      pc_d = redirect_word;
    end
  end

  // FIFO pointer/occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      pc_q     <= ResetPcWord;
      addr_q   <= ResetPcWord;
      req_q    <= 1'b0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= addr_q;
      fifo_data_q[wr_ptr_q] <= bus.ic_rd_data;
    end
  end

  assign bus.ic_addr    = addr_q;
  assign bus.ic_rd_req  = req_q;
  assign bus.inst_valid = !empty;
  assign bus.inst_data  = empty ? 32'h0 : fifo_data_q[rd_ptr_q];
  assign bus.inst_pc    = empty ? 32'h0 : fifo_pc_q[rd_ptr_q];
  assign bus.fifo_count = count_q;

  push_not_full_a: assert property (@(posedge clk) disable iff (!rstn) !(push && full));

endmodule
